display_scan_n: RTL and testbench

DISPLAY_SCAN_N -- requirements
Module: display_scan_n

---
 rtl/display_scan_n.sv | 205 ++++++++++++++++++++
 tb/tb_display_scan_n.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/display_scan_n.sv
// Multiplexed N-digit seven-segment scanner with double-buffered digit data,
// per-digit blinking and leading-zero suppression. All outputs are registered, active low.
module display_scan_n #(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   Value,
    input  logic [DIGITS-1:0]     Points,
    input  logic [DIGITS-1:0]     BlinkMask,
    input  logic                  Lzs,
    output logic [6:0]            Output,
    output logic [DIGITS-1:0]     DigitoLigado,
    output logic                  Ponto,
    output logic                  FrameDone
);

    localparam int PW = $clog2(PRESCALE);
    localparam int IW = $clog2(DIGITS);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [IW-1:0] IDX_ONE    = IW'(1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [FW-1:0] FRAME_ONE  = FW'(1);
    localparam logic [6:0]    SEG_DARK   = 7'h7F;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = SEG_DARK;
        endcase
        return seg;
    endfunction

    logic [PW-1:0]         presc_r;
    logic [IW-1:0]         idx_r;
    logic [FW-1:0]         frame_r;
    logic                  blink_r;
    logic [4*DIGITS-1:0]   pend_val_r;
    logic [DIGITS-1:0]     pend_pts_r;
    logic [DIGITS-1:0]     pend_blk_r;
    logic [4*DIGITS-1:0]   act_val_r;
    logic [DIGITS-1:0]     act_pts_r;
    logic [DIGITS-1:0]     act_blk_r;
    logic [6:0]            seg_r;
    logic [DIGITS-1:0]     dig_r;
    logic                  pt_r;
    logic                  fd_r;

    logic                  tick_s;
    logic                  wrap_s;
    logic [PW-1:0]         presc_nxt_s;
    logic [IW-1:0]         idx_nxt_s;
    logic [FW-1:0]         frame_nxt_s;
    logic                  blink_nxt_s;
    logic [4*DIGITS-1:0]   act_val_nxt_s;
    logic [DIGITS-1:0]     act_pts_nxt_s;
    logic [DIGITS-1:0]     act_blk_nxt_s;

    logic [3:0]            nib_s;
    logic                  pt_req_s;
    logic                  blk_req_s;
    logic                  supp_s;
    logic                  zero_run_s;
    logic [DIGITS-1:0]     dig_s;
    logic                  blank_s;

    // Slot/frame timing and the next active bank (a Load on the wrap tick bypasses pending).
    always_comb begin
        tick_s        = Enable && (presc_r == PRESC_LAST);
        wrap_s        = tick_s && (idx_r == IDX_LAST);
        presc_nxt_s   = presc_r;
        idx_nxt_s     = idx_r;
        frame_nxt_s   = frame_r;
        blink_nxt_s   = blink_r;
        act_val_nxt_s = act_val_r;
        act_pts_nxt_s = act_pts_r;
        act_blk_nxt_s = act_blk_r;
        if (Enable) begin
            presc_nxt_s = tick_s ? {PW{1'b0}} : (presc_r + PRESC_ONE);
        end else begin
            presc_nxt_s = presc_r;
        end
        if (tick_s) begin
            idx_nxt_s = wrap_s ? {IW{1'b0}} : (idx_r + IDX_ONE);
        end else begin
            idx_nxt_s = idx_r;
        end
        if (wrap_s) begin
            frame_nxt_s   = (frame_r == FRAME_LAST) ? {FW{1'b0}} : (frame_r + FRAME_ONE);
            blink_nxt_s   = blink_r ^ (frame_r == FRAME_LAST);
            act_val_nxt_s = Load ? Value     : pend_val_r;
            act_pts_nxt_s = Load ? Points    : pend_pts_r;
            act_blk_nxt_s = Load ? BlinkMask : pend_blk_r;
        end else begin
            frame_nxt_s   = frame_r;
            blink_nxt_s   = blink_r;
        end
    end

    // Select the digit about to be shown; zero_run_s tracks "this digit and all above are zero".
    always_comb begin
        nib_s      = 4'h0;
        pt_req_s   = 1'b0;
        blk_req_s  = 1'b0;
        supp_s     = 1'b0;
        zero_run_s = 1'b1;
        dig_s      = {DIGITS{1'b1}};
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run_s = zero_run_s & (act_val_nxt_s[4*i +: 4] == 4'h0);
            nib_s      = nib_s | (act_val_nxt_s[4*i +: 4] & {4{idx_nxt_s == IW'(i)}});
            pt_req_s   = pt_req_s  | (act_pts_nxt_s[i] & (idx_nxt_s == IW'(i)));
            blk_req_s  = blk_req_s | (act_blk_nxt_s[i] & (idx_nxt_s == IW'(i)));
            supp_s     = supp_s | ((idx_nxt_s == IW'(i)) & Lzs & zero_run_s & (i != 0));
            dig_s[i]   = ~(idx_nxt_s == IW'(i));
        end
        blank_s = blink_nxt_s & blk_req_s;
    end

    // Prescaler, digit index, frame counter and blink phase.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            presc_r <= {PW{1'b0}};
            idx_r   <= {IW{1'b0}};
            frame_r <= {FW{1'b0}};
            blink_r <= 1'b0;
        end else begin
            presc_r <= presc_nxt_s;
            idx_r   <= idx_nxt_s;
            frame_r <= frame_nxt_s;
            blink_r <= blink_nxt_s;
        end
    end

    // Pending and active digit banks; active only changes on a frame boundary.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pend_val_r <= {(4*DIGITS){1'b0}};
            pend_pts_r <= {DIGITS{1'b0}};
            pend_blk_r <= {DIGITS{1'b0}};
            act_val_r  <= {(4*DIGITS){1'b0}};
            act_pts_r  <= {DIGITS{1'b0}};
            act_blk_r  <= {DIGITS{1'b0}};
        end else begin
            if (Load) begin
                pend_val_r <= Value;
                pend_pts_r <= Points;
                pend_blk_r <= BlinkMask;
            end
            act_val_r <= act_val_nxt_s;
            act_pts_r <= act_pts_nxt_s;
            act_blk_r <= act_blk_nxt_s;
        end
    end

    // Registered drive of segments, digit enables, decimal point and frame pulse.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            seg_r <= SEG_DARK;
            dig_r <= {DIGITS{1'b1}};
            pt_r  <= 1'b1;
            fd_r  <= 1'b0;
        end else begin
            fd_r <= wrap_s;
            if (!Enable) begin
                seg_r <= SEG_DARK;
                dig_r <= {DIGITS{1'b1}};
                pt_r  <= 1'b1;
            end else if (tick_s) begin
                seg_r <= (blank_s || supp_s) ? SEG_DARK : hex7(nib_s);
                dig_r <= dig_s;
                pt_r  <= blank_s ? 1'b1 : ~pt_req_s;
            end
        end
    end

    assign Output       = seg_r;
    assign DigitoLigado = dig_r;
    assign Ponto        = pt_r;
    assign FrameDone    = fd_r;

endmodule

// File: tb/tb_display_scan_n.sv
// Scoreboard bench for display_scan_n: the driver predicts each cycle's outputs from
// slot/frame arithmetic and queues them; a monitor pops and compares after every edge.
module tb_display_scan_n;

    localparam int D  = 4;
    localparam int P  = 4;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst, en, ld, lzs;
    logic [15:0] val;
    logic [3:0]  pts, msk;
    logic [6:0]  seg;
    logic [3:0]  dig;
    logic        pt, fd;

    always #5 clk = ~clk;

    display_scan_n #(.DIGITS(D), .PRESCALE(P), .BLINK_FRAMES(BF)) dut (
        .Clock(clk), .Reset(rst), .Enable(en), .Load(ld), .Value(val), .Points(pts),
        .BlinkMask(msk), .Lzs(lzs), .Output(seg), .DigitoLigado(dig), .Ponto(pt),
        .FrameDone(fd)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] dig;
        logic       pt;
        logic       fd;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          fails  = 0;
    logic [6:0]  hex_tab [16];

    // model state: enabled cycles since reset, pending/active banks, current expected outputs
    int          en_cnt;
    logic [15:0] m_pval, m_aval;
    logic [3:0]  m_ppts, m_apts, m_pmsk, m_amsk;
    exp_t        m_out;

    // current stimulus settings used by run()
    logic        c_en, c_lzs;
    logic [15:0] c_val;
    logic [3:0]  c_pts, c_msk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the following edge.
    task automatic step(input logic r, input logic e, input logic l, input logic [15:0] v,
                        input logic [3:0] p, input logic [3:0] m, input logic z);
        int         t, i;
        bit         tick, wrap, blink, supp;
        logic [3:0] nib;
        @(negedge clk);
        rst = r; en = e; ld = l; val = v; pts = p; msk = m; lzs = z;
        if (r) begin
            en_cnt = 0;
            m_pval = 16'h0; m_aval = 16'h0;
            m_ppts = 4'h0;  m_apts = 4'h0;
            m_pmsk = 4'h0;  m_amsk = 4'h0;
            m_out  = '{seg: 7'h7F, dig: 4'hF, pt: 1'b1, fd: 1'b0};
        end else begin
            tick = e && (en_cnt % P == P - 1);
            if (e) en_cnt++;
            t    = en_cnt / P;
            wrap = tick && (t % D == 0);
            if (wrap) begin
                m_aval = l ? v : m_pval;
                m_apts = l ? p : m_ppts;
                m_amsk = l ? m : m_pmsk;
            end
            if (l) begin
                m_pval = v; m_ppts = p; m_pmsk = m;
            end
            m_out.fd = wrap;
            if (!e) begin
                m_out.seg = 7'h7F; m_out.dig = 4'hF; m_out.pt = 1'b1;
            end else if (tick) begin
                i     = t % D;
                blink = (((t / D) / BF) % 2) == 1;
                nib   = m_aval[4*i +: 4];
                supp  = z && (i != 0) && ((m_aval >> (4 * i)) == 16'h0);
                m_out.dig = ~(4'b0001 << i);
                if (blink && m_amsk[i]) begin
                    m_out.seg = 7'h7F;
                    m_out.pt  = 1'b1;
                end else begin
                    m_out.seg = supp ? 7'h7F : hex_tab[nib];
                    m_out.pt  = ~m_apts[i];
                end
            end
        end
        q.push_back(m_out);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(1'b0, c_en, 1'b0, c_val, c_pts, c_msk, c_lzs);
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] p, input logic [3:0] m);
        c_val = v; c_pts = p; c_msk = m;
        step(1'b0, c_en, 1'b1, v, p, m, c_lzs);
    endtask

    // Monitor: compare every registered output after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("Output",       {25'h0, seg}, {25'h0, e.seg});
                chk("DigitoLigado", {28'h0, dig}, {28'h0, e.dig});
                chk("Ponto",        {31'h0, pt},  {31'h0, e.pt});
                chk("FrameDone",    {31'h0, fd},  {31'h0, e.fd});
            end
        end
    end

    initial begin
        hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        rst = 1'b1; en = 1'b0; ld = 1'b0; val = 16'h0; pts = 4'h0; msk = 4'h0; lzs = 1'b0;
        c_en = 1'b0; c_lzs = 1'b0; c_val = 16'h0; c_pts = 4'h0; c_msk = 4'h0;

        step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);

        // basic scan: first frame from zero bank, then 1234
        load(16'h1234, 4'h0, 4'h0);
        c_en = 1'b1;
        run(48);

        // tear-free update: load mid-frame
        run(6);
        load(16'hFFFF, 4'h0, 4'h0);
        run(30);

        // blink on digit 0
        load(16'h0008, 4'h0, 4'b0001);
        run(160);

        // leading-zero suppression, point on a suppressed digit
        c_lzs = 1'b1;
        load(16'h0050, 4'b1000, 4'h0);
        run(40);
        load(16'h0000, 4'h0, 4'h0);
        run(40);

        // enable drop mid-slot, then resume
        c_lzs = 1'b0;
        load(16'hC0DE, 4'b0101, 4'h0);
        run(22);
        c_en = 1'b0;
        run(5);
        load(16'h4321, 4'h0, 4'h0);
        run(3);
        c_en = 1'b1;
        run(40);

        // reset mid-frame with a pending load
        run(5);
        load(16'h9ABC, 4'hF, 4'h0);
        run(2);
        step(1'b1, 1'b1, 1'b1, 16'h5555, 4'hF, 4'hF, 1'b0);
        c_val = 16'h0; c_pts = 4'h0; c_msk = 4'h0;
        run(40);

        // load every cycle, so loads land on wrap ticks
        for (int k = 0; k < 40; k++) load(16'(k * 16'h1111 + 16'h0123), 4'(k), 4'h0);
        run(20);

        // randomized traffic
        for (int k = 0; k < 2500; k++) begin
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom), 4'($urandom),
                 1'($urandom));
        end

        @(posedge clk);
        #2;
        chk("queue drained", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
